// File: rtl/spi_cfg_pkg.sv
// Shared FSM type, frame layout constants and frame builder for the SPI configuration controller.
package spi_cfg_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int WRITE_FLAG_BIT = 15;
  localparam int ADDR_W         = 7;
  localparam int DATA_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_t;

  // Write frame: flag bit on top, then the 7-bit address, then the data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] data);
    logic [FRAME_BITS-1:0] f;
    f                             = '0;
    f[WRITE_FLAG_BIT]             = 1'b1;
    f[WRITE_FLAG_BIT-1 -: ADDR_W] = addr;
    f[DATA_W-1:0]                 = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_idx = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_q;
      default: grant_idx = 1'b0;
    endcase
    grant = 2'b00;
    if (req != 2'b00) grant = grant_idx ? 2'b10 : 2'b01;
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)          last_q <= 1'b1;
    else if (advance) last_q <= grant_idx;
  end

endmodule

// File: rtl/spi_cfg_controller.sv
// Arbitrated register-write SPI master (mode 0, 16-bit frames) for the on-chip PWM peripheral.
// Optional register mirror output enabled by defining SPI_CFG_SHADOW_EN.
module spi_cfg_controller
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_ADDR   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              SCLK,
  output logic              COPI,
  output logic              nCS,
  output logic              busy,
  output logic              grant_id,
  output logic              err_addr
`ifdef SPI_CFG_SHADOW_EN
  ,
  output logic [8*(MAX_ADDR+1)-1:0] shadow_regs
`endif
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;

  logic [1:0]        req_vec, grant;
  logic              grant_idx, accept, bad_addr, in_frame;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // A requester whose ready is showing is masked so the same request is not taken twice.
  assign req_vec  = (state_q == IDLE) ? {req1_valid & ~req1_ready, req0_valid & ~req0_ready} : 2'b00;
  assign accept   = |req_vec;
  assign sel_addr = grant_idx ? req1_addr : req0_addr;
  assign sel_data = grant_idx ? req1_data : req0_data;
  assign bad_addr = sel_addr > ADDR_W'(MAX_ADDR);
  assign in_frame = (state_q == SETUP) || (state_q == SHIFT_HI) || (state_q == SHIFT_LO);

  spi_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_vec),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (accept && !bad_addr) begin
          state_d = SETUP;
          bit_d   = 4'd15;
          shift_d = build_frame(sel_addr, sel_data);
        end
      end
      SETUP: if (div_q == DIV_LAST) begin
        state_d = SHIFT_HI;
        div_d   = '0;
      end
      SHIFT_HI: if (div_q == DIV_LAST) begin
        state_d = SHIFT_LO;
        div_d   = '0;
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
      SHIFT_LO: if (div_q == DIV_LAST) begin
        div_d = '0;
        if (bit_q == 4'd0) begin
          state_d = GAP;
        end else begin
          state_d = SHIFT_HI;
          bit_d   = bit_q - 4'd1;
        end
      end
      GAP: if (div_q == GAP_LAST) begin
        state_d = IDLE;
        div_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from the current state, so they trail the state by one cycle;
  // busy is registered from the next state so it matches the state exactly.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      err_addr   <= 1'b0;
      grant_id   <= 1'b0;
      SCLK       <= 1'b0;
      COPI       <= 1'b0;
      nCS        <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      req0_ready <= grant[0];
      req1_ready <= grant[1];
      err_addr   <= accept & bad_addr;
      if (accept) grant_id <= grant_idx;
      SCLK       <= (state_q == SHIFT_HI);
      COPI       <= in_frame & shift_q[FRAME_BITS-1];
      nCS        <= ~in_frame;
      busy       <= (state_d != IDLE);
    end
  end

`ifdef SPI_CFG_SHADOW_EN
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Mirror is written at the edge where nCS rises, i.e. the first GAP cycle.
  // NOTE: the mirror is small and software-visible, so it is reset like ordinary registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      data_q      <= '0;
      shadow_regs <= '0;
    end else begin
      if (accept && !bad_addr) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
      if (state_q == GAP && div_q == '0) begin
        for (int i = 0; i <= MAX_ADDR; i++) begin
          if (addr_q == ADDR_W'(i)) shadow_regs[8*i +: 8] <= data_q;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Self-checking bench for spi_cfg_controller: directed scenarios plus randomized rounds
// scored against a frame-level model of arbitration and serialisation.
module tb_spi_cfg_controller;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int MAX_ADDR   = 4;
  localparam int LOW_LEN    = 33 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, SCLK, COPI, nCS, busy, grant_id, err_addr;
`ifdef SPI_CFG_SHADOW_EN
  logic [8*(MAX_ADDR+1)-1:0] shadow_regs;
`endif

  always #5 clk = ~clk;

  spi_cfg_controller #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .MAX_ADDR(MAX_ADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .SCLK       (SCLK),
    .COPI       (COPI),
    .nCS        (nCS),
    .busy       (busy),
    .grant_id   (grant_id),
    .err_addr   (err_addr)
`ifdef SPI_CFG_SHADOW_EN
    ,
    .shadow_regs(shadow_regs)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive pin monitor: rebuilds each frame from COPI at SCLK rising edges.
  logic        ncs_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0;
  logic [15:0] mon_frame = '0;
  int          mon_bits = 0, mon_low = 0, ready_cnt = 0;
  logic [15:0] frames[$];
  int          bits_q[$], low_q[$], fall_q[$], rise_q[$], busy_fall_q[$];

  always @(negedge clk) begin
    if (ncs_prev === 1'b1 && nCS === 1'b0) begin
      mon_frame = '0;
      mon_bits  = 0;
      mon_low   = 0;
      fall_q.push_back(cyc);
    end
    if (nCS === 1'b0) begin
      mon_low++;
      if (SCLK === 1'b1 && sclk_prev === 1'b0) begin
        mon_frame = {mon_frame[14:0], COPI};
        mon_bits++;
      end
    end
    if (ncs_prev === 1'b0 && nCS === 1'b1) begin
      frames.push_back(mon_frame);
      bits_q.push_back(mon_bits);
      low_q.push_back(mon_low);
      rise_q.push_back(cyc);
    end
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_q.push_back(cyc);
    if (req0_ready === 1'b1 || req1_ready === 1'b1) ready_cnt++;
    ncs_prev  = nCS;
    sclk_prev = SCLK;
    busy_prev = busy;
  end

  // Reference model state.
  logic        model_last = 1'b1;
  logic [15:0] exp_frames[$];
  int          exp_acc[$];
  int          acc_log[$];
  int          n_acc = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic flush_all();
    frames.delete(); bits_q.delete(); low_q.delete(); fall_q.delete();
    rise_q.delete(); busy_fall_q.delete(); exp_frames.delete(); exp_acc.delete();
  endtask

  // Present one or both requests and hold each until its ready is seen.
  task automatic run_round(input logic v0, input logic [6:0] a0, input logic [7:0] d0,
                           input logic v1, input logic [6:0] a1, input logic [7:0] d1);
    logic       pend0, pend1, exp_idx, exp_bad;
    logic [6:0] exp_a;
    logic [7:0] exp_d;
    int         waited;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    pend0 = v0; pend1 = v1; waited = 0;
    while ((pend0 || pend1) && waited < 400) begin
      step();
      waited++;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        exp_idx = (pend0 && pend1) ? ~model_last : pend1;
        exp_a   = exp_idx ? a1 : a0;
        exp_d   = exp_idx ? d1 : d0;
        exp_bad = (int'(exp_a) > MAX_ADDR);
        check("ready_onehot", {req1_ready, req0_ready}, exp_idx ? 2'b10 : 2'b01);
        check("grant_id", grant_id, exp_idx);
        check("err_addr", err_addr, exp_bad);
        if (exp_bad) check("reject_pins_busy_ncs", {busy, nCS}, 2'b01);
        else begin
          exp_frames.push_back({1'b1, exp_a, exp_d});
          exp_acc.push_back(cyc);
        end
        model_last = exp_idx;
        acc_log.push_back(cyc);
        n_acc++;
        if (req1_ready === 1'b1) begin pend1 = 1'b0; req1_valid = 1'b0; end
        else begin pend0 = 1'b0; req0_valid = 1'b0; end
      end
    end
    check("round_done", {pend1, pend0}, 2'b00);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Wait for the bus to go quiet, then score every captured frame against the model.
  task automatic check_frames(input string tag);
    int waited, acc, fall, bfall;
    waited = 0;
    while ((busy !== 1'b0 || nCS !== 1'b1 || frames.size() < exp_frames.size()) && waited < 2000) begin
      step();
      waited++;
    end
    check({tag, "_frame_count"}, frames.size(), exp_frames.size());
    while (exp_frames.size() > 0 && frames.size() > 0) begin
      acc   = exp_acc.pop_front();
      fall  = (fall_q.size() > 0) ? fall_q.pop_front() : -1;
      bfall = (busy_fall_q.size() > 0) ? busy_fall_q.pop_front() : -1;
      check({tag, "_frame"}, frames.pop_front(), exp_frames.pop_front());
      check({tag, "_sclk_edges"}, bits_q.pop_front(), 16);
      check({tag, "_ncs_low_len"}, low_q.pop_front(), LOW_LEN);
      check({tag, "_ncs_fall_cycle"}, fall, acc + 1);
      check({tag, "_busy_fall_cycle"}, bfall, acc + LOW_LEN + GAP_CYCLES);
    end
    flush_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, waited, sel;
    logic [6:0] ra0, ra1;
    logic [7:0] rd0, rd1;
`ifdef SPI_CFG_SHADOW_EN
    logic [8*(MAX_ADDR+1)-1:0] snap, exp_sh, pre;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    step();
    rst = 1'b0;
    check("reset_pins", {nCS, SCLK, COPI, busy}, 4'b1000);
    check("reset_handshake", {req0_ready, req1_ready, err_addr, grant_id}, 4'b0000);
`ifdef SPI_CFG_SHADOW_EN
    check("reset_shadow", shadow_regs, '0);
`endif
    flush_all();

    // Single write 0x00 <- 0xA5 gives frame 0x80A5
    run_round(1'b1, 7'h00, 8'hA5, 1'b0, 7'h00, 8'h00);
    check_frames("single");

    // Simultaneous requests alternate, starting with requester 0
    run_round(1'b1, 7'h02, 8'h3C, 1'b1, 7'h04, 8'h80);
    run_round(1'b1, 7'h01, 8'h11, 1'b1, 7'h03, 8'h22);
    check_frames("rr");

    // Out-of-range address from requester 1, requester 0 served the next cycle
    run_round(1'b1, 7'h00, 8'h01, 1'b0, 7'h00, 8'h00);
    run_round(1'b1, 7'h04, 8'h77, 1'b1, 7'h05, 8'h99);
    check("reject_then_next_cycle", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 1);
    check_frames("reject");

    // Reset during the high phase of bit 7 abandons the frame
    run_round(1'b1, 7'h01, 8'h5A, 1'b0, 7'h00, 8'h00);
    waited = 0;
    while (!(mon_bits == 9 && SCLK === 1'b1 && nCS === 1'b0) && waited < 300) begin
      step();
      waited++;
    end
    check("abort_reached_bit7", mon_bits, 9);
    rst = 1'b1;
    step();
    check("abort_reset_pins", {nCS, SCLK, COPI, busy}, 4'b1000);
    rst = 1'b0;
    model_last = 1'b1;
    flush_all();
    run_round(1'b1, 7'h02, 8'hC3, 1'b1, 7'h03, 8'h3C);
    check_frames("post_abort");

    // Requester 0 held valid across two writes
    req0_valid = 1'b1; req0_addr = 7'h02; req0_data = 8'h11;
    waited = 0;
    do begin step(); waited++; end while (req0_ready !== 1'b1 && waited < 400);
    t1 = cyc;
    exp_frames.push_back({1'b1, 7'h02, 8'h11}); exp_acc.push_back(t1);
    model_last = 1'b0; n_acc++;
    req0_addr = 7'h03; req0_data = 8'h22;
    waited = 0;
    do begin step(); waited++; end while (req0_ready !== 1'b1 && waited < 400);
    t2 = cyc;
    exp_frames.push_back({1'b1, 7'h03, 8'h22}); exp_acc.push_back(t2);
    n_acc++;
    req0_valid = 1'b0;
    check("back_to_back_spacing", t2 - t1, 1 + LOW_LEN + GAP_CYCLES);
    check("back_to_back_ncs_high", (rise_q.size() > 0) ? t2 - rise_q[0] : -1, GAP_CYCLES);
    check_frames("hold");

    // Randomized rounds against the model
    for (int r = 0; r < 14; r++) begin
      sel = $urandom_range(1, 3);
      ra0 = 7'($urandom_range(0, 6));
      ra1 = 7'($urandom_range(0, 6));
      rd0 = 8'($urandom);
      rd1 = 8'($urandom);
      run_round(sel[0], ra0, rd0, sel[1], ra1, rd1);
    end
    check_frames("rand");

`ifdef SPI_CFG_SHADOW_EN
    // Mirror updates exactly when nCS rises; rejected writes leave it alone
    snap = shadow_regs;
    run_round(1'b1, 7'h03, 8'hFF, 1'b0, 7'h00, 8'h00);
    exp_sh = snap;
    exp_sh[24 +: 8] = 8'hFF;
    pre = snap;
    waited = 0;
    while (nCS !== 1'b0 && waited < 50) begin step(); waited++; end
    while (nCS !== 1'b1 && waited < 400) begin pre = shadow_regs; step(); waited++; end
    check("shadow_before_rise", pre, snap);
    check("shadow_at_rise", shadow_regs, exp_sh);
    run_round(1'b0, 7'h00, 8'h00, 1'b1, 7'h06, 8'h12);
    repeat (3) step();
    check("shadow_after_reject", shadow_regs, exp_sh);
    check_frames("shadow");
`endif

    check("ready_pulse_total", ready_cnt, n_acc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
